// File: rtl/video_dnn_argmax_pkg.sv
// Shared types and constant helpers for the per-pixel class argmax pipeline.
package video_dnn_argmax_pkg;

   // Tree pairs use fixed maximum widths; unused upper bits are constant zero.
   localparam int unsigned IdxW      = 6;
   localparam int unsigned CntW      = 32;
   localparam int unsigned MaxFieldW = 64;

   typedef struct packed {
      logic [IdxW-1:0] idx;
      logic [CntW-1:0] cnt;
   } pair_t;

   function automatic int unsigned tree_depth(input int unsigned n);
      int unsigned d;
      d = 0;
      for (int unsigned i = 0; i < 7; i++) begin
         if ((32'd1 << i) < n) d = i + 1;
      end
      return d;
   endfunction

   function automatic int unsigned level_nodes(input int unsigned n, input int unsigned lvl);
      return (n + (32'd1 << lvl) - 32'd1) >> lvl;
   endfunction

   function automatic logic [CntW-1:0] popcount(input logic [MaxFieldW-1:0] v);
      logic [CntW-1:0] c;
      c = '0;
      for (int i = 0; i < MaxFieldW; i++) c = c + CntW'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/video_dnn_argmax_node.sv
// Registered two-input compare node; ties keep the left (lower-index) operand.
module video_dnn_argmax_node
   import video_dnn_argmax_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  cke,
   input  logic  in_valid,
   input  pair_t left,
   input  pair_t right,
   output logic  out_valid,
   output pair_t winner
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         winner    <= '0;
      end else if (cke) begin
         out_valid <= in_valid;
         winner    <= (right.cnt > left.cnt) ? right : left;
      end
   end

endmodule

// File: rtl/video_dnn_argmax.sv
// Pipelined per-pixel argmax over class fields with frame-latched background threshold.
module video_dnn_argmax
   import video_dnn_argmax_pkg::*;
#(
   parameter int unsigned NUM_CLASS     = 11,
   parameter int unsigned CHANNEL_WIDTH = 1,
   parameter int unsigned SCORE_MODE    = 0,
   parameter int unsigned TUSER_WIDTH   = 1,
   parameter int unsigned TNUMBER_WIDTH = 4,
   parameter int unsigned TCOUNT_WIDTH  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [TCOUNT_WIDTH-1:0]            param_threshold,
   input  logic [TNUMBER_WIDTH-1:0]           param_background,
   input  logic                               param_bg_enable,
   input  logic [TUSER_WIDTH-1:0]             s_axi4s_tuser,
   input  logic                               s_axi4s_tlast,
   input  logic [NUM_CLASS*CHANNEL_WIDTH-1:0] s_axi4s_tdata,
   input  logic                               s_axi4s_tvalid,
   output logic                               s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]             m_axi4s_tuser,
   output logic                               m_axi4s_tlast,
   output logic [TNUMBER_WIDTH-1:0]           m_axi4s_tnumber,
   output logic [TCOUNT_WIDTH-1:0]            m_axi4s_tcount,
   output logic [NUM_CLASS-1:0]               m_axi4s_tmask,
   output logic                               m_axi4s_tvalid,
   input  logic                               m_axi4s_tready
);

   localparam int unsigned Depth   = tree_depth(NUM_CLASS);
   localparam int unsigned CntVecW = NUM_CLASS * TCOUNT_WIDTH;

   if (NUM_CLASS < 2 || NUM_CLASS > 64 || TNUMBER_WIDTH < $clog2(NUM_CLASS) ||
       TCOUNT_WIDTH > CntW || TUSER_WIDTH < 1 ||
       (SCORE_MODE == 0 && (CHANNEL_WIDTH > MaxFieldW ||
                            TCOUNT_WIDTH < $clog2(CHANNEL_WIDTH + 1))) ||
       (SCORE_MODE != 0 && TCOUNT_WIDTH < CHANNEL_WIDTH)) begin : g_bad_params
      $error("video_dnn_argmax: unsupported parameter combination");
   end

   logic                     cke;
   logic                     load;
   logic [TCOUNT_WIDTH-1:0]  thr_s_q, thr_eff;
   logic [TNUMBER_WIDTH-1:0] bg_s_q, bg_eff;
   logic                     en_s_q, en_eff;
   logic [CntVecW-1:0]       cnt_in;

   assign cke            = !m_axi4s_tvalid || m_axi4s_tready;
   assign s_axi4s_tready = cke;

   // A frame-start beat sees the new parameters because they ride with it.
   assign load    = s_axi4s_tvalid && cke && s_axi4s_tuser[0];
   assign thr_eff = load ? param_threshold  : thr_s_q;
   assign bg_eff  = load ? param_background : bg_s_q;
   assign en_eff  = load ? param_bg_enable  : en_s_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         thr_s_q <= '0;
         bg_s_q  <= '0;
         en_s_q  <= 1'b0;
      end else if (load) begin
         thr_s_q <= param_threshold;
         bg_s_q  <= param_background;
         en_s_q  <= param_bg_enable;
      end
   end

   always_comb begin
      cnt_in = '0;
      for (int i = 0; i < NUM_CLASS; i++) begin
         if (SCORE_MODE == 0) begin
            cnt_in[i*TCOUNT_WIDTH +: TCOUNT_WIDTH] = TCOUNT_WIDTH'(popcount(
               MaxFieldW'(s_axi4s_tdata[i*CHANNEL_WIDTH +: CHANNEL_WIDTH])));
         end else begin
            cnt_in[i*TCOUNT_WIDTH +: TCOUNT_WIDTH] =
               TCOUNT_WIDTH'(s_axi4s_tdata[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
         end
      end
   end

   // Index 0 is the count stage; index l lines up with tree level l.
   logic                     s0_vld_q;
   logic [TUSER_WIDTH-1:0]   user_dly [Depth+1];
   logic [Depth:0]           last_dly;
   logic [TCOUNT_WIDTH-1:0]  thr_dly  [Depth+1];
   logic [TNUMBER_WIDTH-1:0] bg_dly   [Depth+1];
   logic [Depth:0]           en_dly;
   logic [CntVecW-1:0]       cnt_dly  [Depth+1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_vld_q <= 1'b0;
         last_dly <= '0;
         en_dly   <= '0;
         for (int l = 0; l <= Depth; l++) begin
            user_dly[l] <= '0;
            thr_dly[l]  <= '0;
            bg_dly[l]   <= '0;
            cnt_dly[l]  <= '0;
         end
      end else if (cke) begin
         s0_vld_q    <= s_axi4s_tvalid;
         user_dly[0] <= s_axi4s_tuser;
         last_dly[0] <= s_axi4s_tlast;
         thr_dly[0]  <= thr_eff;
         bg_dly[0]   <= bg_eff;
         en_dly[0]   <= en_eff;
         cnt_dly[0]  <= cnt_in;
         for (int l = 1; l <= Depth; l++) begin
            user_dly[l] <= user_dly[l-1];
            last_dly[l] <= last_dly[l-1];
            thr_dly[l]  <= thr_dly[l-1];
            bg_dly[l]   <= bg_dly[l-1];
            en_dly[l]   <= en_dly[l-1];
            cnt_dly[l]  <= cnt_dly[l-1];
         end
      end
   end

   pair_t          lvl      [Depth+1][NUM_CLASS];
   logic           node_vld [Depth][NUM_CLASS];
   logic [Depth:0] lvl_vld;

   assign lvl_vld[0] = s0_vld_q;

   for (genvar i = 0; i < NUM_CLASS; i++) begin : g_leaf
      assign lvl[0][i] = '{idx: IdxW'(i),
                           cnt: CntW'(cnt_dly[0][i*TCOUNT_WIDTH +: TCOUNT_WIDTH])};
   end

   for (genvar l = 1; l <= Depth; l++) begin : g_level
      localparam int unsigned Nodes = level_nodes(NUM_CLASS, l);
      localparam int unsigned Prev  = level_nodes(NUM_CLASS, l - 1);
      for (genvar j = 0; j < NUM_CLASS; j++) begin : g_node
         if (j < Nodes) begin : g_used
            pair_t rhs;
            if (2 * j + 1 < Prev) begin : g_pair
               assign rhs = lvl[l-1][2*j+1];
            end else begin : g_odd
               // A zero count never beats the left operand, so it passes through.
               assign rhs = '0;
            end
            video_dnn_argmax_node u_node (
               .clk       (clk),
               .reset     (reset),
               .cke       (cke),
               .in_valid  (lvl_vld[l-1]),
               .left      (lvl[l-1][2*j]),
               .right     (rhs),
               .out_valid (node_vld[l-1][j]),
               .winner    (lvl[l][j])
            );
         end else begin : g_unused
            assign lvl[l][j]        = '0;
            assign node_vld[l-1][j] = 1'b0;
         end
      end
      assign lvl_vld[l] = node_vld[l-1][0];
   end

   pair_t                    top;
   logic [TCOUNT_WIDTH-1:0]  max_cnt;
   logic                     below;
   logic [TNUMBER_WIDTH-1:0] number_d;
   logic [NUM_CLASS-1:0]     mask_d;

   assign top     = lvl[Depth][0];
   assign max_cnt = TCOUNT_WIDTH'(top.cnt);

   always_comb begin
      mask_d = '0;
      for (int i = 0; i < NUM_CLASS; i++) begin
         mask_d[i] = (cnt_dly[Depth][i*TCOUNT_WIDTH +: TCOUNT_WIDTH] == max_cnt);
      end
      below    = en_dly[Depth] && (max_cnt < thr_dly[Depth]);
      number_d = TNUMBER_WIDTH'(top.idx);
      if (below) begin
         number_d = bg_dly[Depth];
         mask_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_axi4s_tvalid  <= 1'b0;
         m_axi4s_tuser   <= '0;
         m_axi4s_tlast   <= 1'b0;
         m_axi4s_tnumber <= '0;
         m_axi4s_tcount  <= '0;
         m_axi4s_tmask   <= '0;
      end else if (cke) begin
         m_axi4s_tvalid  <= lvl_vld[Depth];
         m_axi4s_tuser   <= user_dly[Depth];
         m_axi4s_tlast   <= last_dly[Depth];
         m_axi4s_tnumber <= number_d;
         m_axi4s_tcount  <= max_cnt;
         m_axi4s_tmask   <= mask_d;
      end
   end

endmodule

// File: tb/tb_video_dnn_argmax.sv
// Directed bench for video_dnn_argmax: defaults, 4-bit popcount and 8-bit score variants.
module tb_video_dnn_argmax;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        s_user, s_last, s_valid, m_ready, p_en;
   logic [3:0]  p_bg;
   logic        thr_a;
   logic [2:0]  thr_b;
   logic [7:0]  thr_c;
   logic [10:0] d_a;
   logic [43:0] d_b;
   logic [87:0] d_c;

   logic rdy_a, mu_a, ml_a, mv_a, mc_a;
   logic [3:0] mn_a;
   logic [10:0] mm_a;
   logic rdy_b, mu_b, ml_b, mv_b;
   logic [3:0] mn_b;
   logic [2:0] mc_b;
   logic [10:0] mm_b;
   logic rdy_c, mu_c, ml_c, mv_c;
   logic [3:0] mn_c;
   logic [7:0] mc_c;
   logic [10:0] mm_c;

   video_dnn_argmax dut_a (
      .clk(clk), .reset(reset),
      .param_threshold(thr_a), .param_background(p_bg), .param_bg_enable(p_en),
      .s_axi4s_tuser(s_user), .s_axi4s_tlast(s_last), .s_axi4s_tdata(d_a),
      .s_axi4s_tvalid(s_valid), .s_axi4s_tready(rdy_a),
      .m_axi4s_tuser(mu_a), .m_axi4s_tlast(ml_a), .m_axi4s_tnumber(mn_a),
      .m_axi4s_tcount(mc_a), .m_axi4s_tmask(mm_a), .m_axi4s_tvalid(mv_a),
      .m_axi4s_tready(m_ready)
   );

   video_dnn_argmax #(.CHANNEL_WIDTH(4), .SCORE_MODE(0), .TCOUNT_WIDTH(3)) dut_b (
      .clk(clk), .reset(reset),
      .param_threshold(thr_b), .param_background(p_bg), .param_bg_enable(p_en),
      .s_axi4s_tuser(s_user), .s_axi4s_tlast(s_last), .s_axi4s_tdata(d_b),
      .s_axi4s_tvalid(s_valid), .s_axi4s_tready(rdy_b),
      .m_axi4s_tuser(mu_b), .m_axi4s_tlast(ml_b), .m_axi4s_tnumber(mn_b),
      .m_axi4s_tcount(mc_b), .m_axi4s_tmask(mm_b), .m_axi4s_tvalid(mv_b),
      .m_axi4s_tready(m_ready)
   );

   video_dnn_argmax #(.CHANNEL_WIDTH(8), .SCORE_MODE(1), .TCOUNT_WIDTH(8)) dut_c (
      .clk(clk), .reset(reset),
      .param_threshold(thr_c), .param_background(p_bg), .param_bg_enable(p_en),
      .s_axi4s_tuser(s_user), .s_axi4s_tlast(s_last), .s_axi4s_tdata(d_c),
      .s_axi4s_tvalid(s_valid), .s_axi4s_tready(rdy_c),
      .m_axi4s_tuser(mu_c), .m_axi4s_tlast(ml_c), .m_axi4s_tnumber(mn_c),
      .m_axi4s_tcount(mc_c), .m_axi4s_tmask(mm_c), .m_axi4s_tvalid(mv_c),
      .m_axi4s_tready(m_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One beat into all three instances with tready high; waits for it at the output.
   task automatic send_beat(input logic u, input logic l, input logic [10:0] a,
                            input logic [43:0] b, input logic [87:0] c, output int lat);
      @(negedge clk);
      s_user = u; s_last = l; d_a = a; d_b = b; d_c = c; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      lat = 1;
      while (!mv_a && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, sent, rcvd, cyc, stale, lo;
      logic acc;
      logic [10:0] cur;
      logic [17:0] e;
      logic [17:0] expq[$];

      reset = 1'b1; s_user = 0; s_last = 0; s_valid = 0; m_ready = 0;
      p_en = 0; p_bg = 0; thr_a = 0; thr_b = 0; thr_c = 0; d_a = 0; d_b = 0; d_c = 0;
      #12;
      check("rst_valid", {31'd0, mv_a}, 0);
      check("rst_out", {mu_a, ml_a, mn_a, mc_a, mm_a}, 0);
      check("rst_ready", {31'd0, rdy_a}, 1);
      check("rst_b", {mv_b, mn_b, mc_b, mm_b}, 0);
      @(negedge clk);
      reset = 1'b0; m_ready = 1'b1;

      // Default: class 3; 4-bit tie classes 2/7; score 201 beats 200.
      send_beat(1, 0, 11'h008, 44'hB000_0700, (88'd200 << 40) | (88'd201 << 72), lat);
      check("v1_lat", lat, 6);
      check("v1_a", {mv_a, mu_a, ml_a, mn_a, mc_a, mm_a}, {3'b110, 4'd3, 1'b1, 11'h008});
      check("v1_b", {mv_b, mu_b, ml_b, mn_b, mc_b, mm_b}, {3'b110, 4'd2, 3'd3, 11'h084});
      check("v1_c", {mv_c, mu_c, ml_c, mn_c, mc_c, mm_c}, {3'b110, 4'd9, 8'd201, 11'h200});

      send_beat(0, 1, 11'h000, 44'h0, 88'hFF | (88'hFF << 80), lat);
      check("v2_a", {mv_a, mu_a, ml_a, mn_a, mc_a, mm_a}, {3'b101, 4'd0, 1'b0, 11'h7FF});
      check("v2_b", {mv_b, mu_b, ml_b, mn_b, mc_b, mm_b}, {3'b101, 4'd0, 3'd0, 11'h7FF});
      check("v2_c", {mv_c, mu_c, ml_c, mn_c, mc_c, mm_c}, {3'b101, 4'd0, 8'd255, 11'h401});

      // Frame start loads background 10 with thresholds a=1, b=3, c=0.
      p_en = 1; p_bg = 4'd10; thr_a = 1; thr_b = 3; thr_c = 0;
      send_beat(1, 0, 11'h000, 44'h5_0000, 88'd7 << 8, lat);
      check("v3_a", {mv_a, mu_a, ml_a, mn_a, mc_a, mm_a}, {3'b110, 4'd10, 1'b0, 11'h000});
      check("v3_b", {mv_b, mu_b, ml_b, mn_b, mc_b, mm_b}, {3'b110, 4'd10, 3'd2, 11'h000});
      check("v3_c", {mv_c, mu_c, ml_c, mn_c, mc_c, mm_c}, {3'b110, 4'd1, 8'd7, 11'h002});

      // Mid-frame parameter changes must not take effect.
      p_en = 0; p_bg = 4'd5; thr_a = 0; thr_b = 1;
      send_beat(0, 0, 11'h000, 44'h30, 88'd0, lat);
      check("v4_a", {mv_a, mu_a, ml_a, mn_a, mc_a, mm_a}, {3'b100, 4'd10, 1'b0, 11'h000});
      check("v4_b", {mv_b, mu_b, ml_b, mn_b, mc_b, mm_b}, {3'b100, 4'd10, 3'd2, 11'h000});
      check("v4_c", {mv_c, mu_c, ml_c, mn_c, mc_c, mm_c}, {3'b100, 4'd0, 8'd0, 11'h7FF});

      send_beat(0, 0, 11'h020, 44'hE00_0000, 88'd1 << 16, lat);
      check("v5_a", {mv_a, mu_a, ml_a, mn_a, mc_a, mm_a}, {3'b100, 4'd5, 1'b1, 11'h020});
      check("v5_b", {mv_b, mu_b, ml_b, mn_b, mc_b, mm_b}, {3'b100, 4'd6, 3'd3, 11'h040});
      check("v5_c", {mv_c, mu_c, ml_c, mn_c, mc_c, mm_c}, {3'b100, 4'd2, 8'd1, 11'h004});

      send_beat(1, 1, 11'h000, 44'h0, 88'd0, lat);
      check("v6_lat", lat, 6);
      check("v6_a", {mv_a, mu_a, ml_a, mn_a, mc_a, mm_a}, {3'b111, 4'd0, 1'b0, 11'h7FF});

      // 64x8 frame under random tready and random input gaps.
      p_en = 1; p_bg = 4'd7; thr_a = 1;
      sent = 0; rcvd = 0; cyc = 0; acc = 0;
      @(posedge clk); #1;
      while (rcvd < 512 && cyc < 20000) begin
         m_ready = 1'($urandom_range(0, 1));
         if (acc) begin
            s_valid = 1'b0;
            acc = 1'b0;
         end
         if (!s_valid && sent < 512 && $urandom_range(0, 3) != 0) begin
            cur = ($urandom_range(0, 3) == 0) ? 11'h000 : 11'($urandom);
            d_a = cur; s_user = (sent == 0); s_last = (sent % 64 == 63); s_valid = 1'b1;
         end
         @(negedge clk);
         if (s_valid && rdy_a) begin
            if (d_a == 11'h000) begin
               e = {s_user, s_last, 4'd7, 1'b0, 11'h000};
            end else begin
               lo = 0;
               for (int k = 10; k >= 0; k--) if (d_a[k]) lo = k;
               e = {s_user, s_last, 4'(lo), 1'b1, d_a};
            end
            expq.push_back(e);
            sent++;
            acc = 1'b1;
         end
         if (mv_a && m_ready) begin
            if (expq.size() == 0) begin
               check("bp_extra", 1, 0);
            end else begin
               check("bp_beat", {mu_a, ml_a, mn_a, mc_a, mm_a}, expq.pop_front());
            end
            rcvd++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
      check("bp_count", rcvd, 512);
      check("bp_drain", expq.size(), 0);

      // Fill the pipeline, then reset asynchronously mid-cycle.
      m_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         s_user = (k == 0); s_last = 0; d_a = 11'(1 << k); s_valid = 1'b1;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      check("pre_rst_valid", {31'd0, mv_a}, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_drop", {31'd0, mv_a}, 0);
      check("rst_num", {28'd0, mn_a}, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      stale = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (mv_a) stale++;
      end
      check("no_stale", stale, 0);

      p_en = 0;
      send_beat(1, 0, 11'h004, 44'h0, 88'd0, lat);
      check("post_lat", lat, 6);
      check("post_a", {mv_a, mu_a, ml_a, mn_a, mc_a, mm_a}, {3'b110, 4'd2, 1'b1, 11'h004});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
